food_spawner: RTL and testbench
===============================

// Module: food_spawner
// PURPOSE
//  Serves food-placement requests raised when a snake eats. On each request it draws LFSR
//  candidates and rejects any that are out of the playfield, equal to the current food,
//  or on a snake segment; the snake body is scanned serially through a read port.
//  The accepted cell is registered as the new food and signalled with a one-cycle done pulse.
//  Sits between the score/food checker (the requester) and the snake body register file.
// PARAMETERS
//  max_len          16    max snake segments
//  num_len          10    cell index width; cell = row*width + col
//  max_len_bit_len  4     segment index width
//  width            32    playfield columns
//  height           24    playfield rows; width*height must be <= 2**num_len
//  seed             10'h1A5  LFSR reset value; must be nonzero
//  init_food        10'd100  food cell after reset
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  async active-low reset
//  req        in   1                  spawn request; sampled only in IDLE
//  snake_len  in   max_len_bit_len+1  live segments, 0..max_len; sampled at req
//  body_idx   out  max_len_bit_len    segment index being read
//  body_pos   in   num_len            cell of segment body_idx, combinational same cycle
//  food       out  num_len            current food cell (registered)
//  busy       out  1                  high in DRAW/SCAN/DONE
//  done       out  1                  one-cycle pulse when food updated
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, food=init_food, lfsr=seed, body_idx=0, busy=0, done=0.
//  LFSR: 10-bit Fibonacci, taps x^10+x^7+1; advances every cycle in all states.
//   Never all-zero.
//  FSM, all transitions on rising clk:
//   IDLE: req=1 -> latch snake_len into len_q, go DRAW. req=0 -> stay.
//   DRAW: cand=lfsr. Reject if cand>=width*height or cand==food; stay DRAW.
//    Else latch cand and set idx=0.
//    Go DONE if len_q==0, else SCAN.
//   SCAN: body_idx=idx. body_pos==cand -> go DRAW, no further segments read.
//    Else if idx==len_q-1 -> DONE. Else idx=idx+1.
//   DONE: food<=cand, done=1 for exactly this cycle, go IDLE.
//  Latency: req sampled at edge N gives done=1 during cycle after edge N+2+len_q.
//   This is the minimum, with first candidate accepted and no hit; each rejection adds cycles.
//  snake_len>max_len is clamped to max_len at latch.
//  req while busy is ignored, not queued. req held high after done starts a new spawn.
//  rst_n asserted mid-operation: immediate IDLE, food keeps init_food, no done pulse.
//  food changes only in DONE; body_pos is treated as stable during SCAN.
// CONFIGURATION
//  FOOD_RETRY_LIMIT_EN defined:
//   - 8-bit reject counter, cleared in IDLE, incremented on each DRAW reject or SCAN hit.
//   - Reaching 255 -> go IDLE with food unchanged.
//   - Extra output fail (1 bit, reset 0) pulses one cycle instead of done.
//  Not defined: no counter, no fail port; FSM retries until success.
// TESTING
//  1 Reset: rst_n=0 then 1 -> food=100, busy=0, done=0, body_idx=0.
//  2 snake_len=0, req pulse -> busy next cycle; done at latency 2 when first cand valid.
//    food matches golden LFSR model from seed 10'h1A5.
//  3 snake_len=4, body cells {5,6,7,8}, no hit -> body_idx steps 0,1,2,3.
//    done 6 cycles after req; food not in {5,6,7,8,100}, and <768.
//  4 Force collision: body_pos=cand on idx 2 -> FSM returns to DRAW after idx 2.
//    Final food != any body cell.
//  5 Assert rst_n low during SCAN idx 1 -> busy=0 immediately; no done; food=100.
//  6 FOOD_RETRY_LIMIT_EN, snake_len=16, body covers every cell -> fail pulse after 255 rejects.
//    food unchanged, done never asserted. Also, req during busy is ignored: exactly one done.

Source files
------------

// File: rtl/food_spawner.sv
// Food placement engine: draws LFSR candidates, rejects off-board/current-food/body cells.
// Optional FOOD_RETRY_LIMIT_EN adds a reject counter that gives up with a fail pulse.
module food_spawner #(
  parameter int unsigned max_len         = 16,
  parameter int unsigned num_len         = 10,
  parameter int unsigned max_len_bit_len = 4,
  parameter int unsigned width           = 32,
  parameter int unsigned height          = 24,
  parameter logic [num_len-1:0] seed      = 10'h1A5,
  parameter logic [num_len-1:0] init_food = 10'd100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [max_len_bit_len:0]   snake_len,
  output logic [max_len_bit_len-1:0] body_idx,
  input  logic [num_len-1:0]         body_pos,
  output logic [num_len-1:0]         food,
  output logic                       busy,
`ifdef FOOD_RETRY_LIMIT_EN
  output logic                       fail,
`endif
  output logic                       done
);

  localparam logic [num_len:0]         CELLS   = (num_len+1)'(width * height);
  localparam logic [max_len_bit_len:0] MAX_LEN = (max_len_bit_len+1)'(max_len);
  localparam logic [max_len_bit_len:0] LEN_ONE = (max_len_bit_len+1)'(1);

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [num_len-1:0]         lfsr_reg, lfsr_next;
  logic [num_len-1:0]         food_reg, food_next;
  logic [num_len-1:0]         cand_reg, cand_next;
  logic [max_len_bit_len:0]   len_reg, len_next;
  logic [max_len_bit_len-1:0] idx_reg, idx_next;
  logic                       done_reg, done_next;
  logic                       reject;

  // Fibonacci LFSR x^10+x^7+1, free-running in every state.
  assign lfsr_next = {lfsr_reg[num_len-2:0], lfsr_reg[num_len-1] ^ lfsr_reg[num_len-4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lfsr_reg  <= seed;
      food_reg  <= init_food;
      cand_reg  <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      food_reg  <= food_next;
      cand_reg  <= cand_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

`ifdef FOOD_RETRY_LIMIT_EN
  logic [7:0] cnt_reg, cnt_next;
  logic       fail_reg, fail_next;
  logic       give_up;

  assign give_up = reject && (cnt_reg == 8'd254);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      fail_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      fail_reg <= fail_next;
    end
  end

  always_comb begin
    cnt_next  = cnt_reg;
    fail_next = 1'b0;
    if (state_reg == IDLE) begin
      cnt_next = '0;
    end else if (give_up) begin
      cnt_next  = '0;
      fail_next = 1'b1;
    end else if (reject) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  assign fail = fail_reg;
`else
  logic give_up;
  assign give_up = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    food_next  = food_reg;
    cand_next  = cand_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    reject     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          len_next   = (snake_len > MAX_LEN) ? MAX_LEN : snake_len;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (({1'b0, lfsr_reg} >= CELLS) || (lfsr_reg == food_reg)) begin
          reject = 1'b1;
        end else begin
          cand_next  = lfsr_reg;
          idx_next   = '0;
          state_next = (len_reg == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (body_pos == cand_reg) begin
          reject     = 1'b1;
          state_next = DRAW;
        end else if ({1'b0, idx_reg} == (len_reg - LEN_ONE)) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        food_next  = cand_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Retry budget exhausted: abandon the spawn, food untouched.
    if (give_up) state_next = IDLE;
  end

  assign body_idx = idx_reg;
  assign food     = food_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner with a reference LFSR used to pick request timing
// and predict the accepted food cell; FOOD_RETRY_LIMIT_EN adds the give-up scenario.
module tb_food_spawner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [4:0] snake_len = '0;
  logic [3:0] body_idx;
  logic [9:0] body_pos;
  logic [9:0] food;
  logic       busy;
  logic       done;
`ifdef FOOD_RETRY_LIMIT_EN
  logic       fail;
`endif

  logic [9:0] body_mem [16];
  logic [9:0] m, m_prev;
  logic       hit_all = 1'b0;
  logic [9:0] food_exp;
  logic [9:0] exp_v;
  int checks = 0;
  int errors = 0;
  int cnt_a, cnt_b;

  food_spawner dut (
    .clk(clk), .rst_n(rst_n), .req(req), .snake_len(snake_len),
    .body_idx(body_idx), .body_pos(body_pos), .food(food), .busy(busy),
`ifdef FOOD_RETRY_LIMIT_EN
    .fail(fail),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // m_prev equals the candidate latched by DRAW, so hit_all makes every scan collide.
  assign body_pos = hit_all ? m_prev : body_mem[body_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= 10'h1A5;
      m_prev <= 10'h1A5;
    end else begin
      m      <= {m[8:0], m[9] ^ m[6]};
      m_prev <= m;
    end
  end

  function automatic logic [9:0] step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  function automatic logic ok(input logic [9:0] v, input logic [9:0] f, input int n);
    logic r;
    r = (v < 10'd768) && (v != f);
    for (int i = 0; i < n; i++) if (body_mem[i] == v) r = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-22s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle until the candidate seen after the next edge will be accepted outright.
  task automatic wait_valid(input int n);
    int k;
    k = 0;
    while (!ok(step(m), food_exp, n) && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) check("wait_valid_timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) body_mem[i] = 10'(200 + i);
    food_exp = 10'd100;

    // 1: reset state
    tick(); tick();
    check("rst_food", food, 100);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_body_idx", body_idx, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // 2: empty snake, minimum latency 2
    wait_valid(0);
    req = 1'b1; snake_len = 5'd0;
    tick();
    req = 1'b0;
    exp_v = m;
    check("l0_busy", busy, 1);
    check("l0_done_n1", done, 0);
    tick();
    check("l0_done_n2", done, 0);
    tick();
    check("l0_done", done, 1);
    check("l0_food", food, exp_v);
    food_exp = exp_v;
    tick();
    check("l0_done_drop", done, 0);
    check("l0_idle", busy, 0);

    // 3: four segments, no hit, req held high while busy
    body_mem[0] = 10'd5; body_mem[1] = 10'd6; body_mem[2] = 10'd7; body_mem[3] = 10'd8;
    wait_valid(4);
    req = 1'b1; snake_len = 5'd4;
    tick();
    exp_v = m;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("l4_idx%0d", i), body_idx, i);
    end
    tick();
    check("l4_done_early", done, 0);
    req = 1'b0;
    tick();
    check("l4_done", done, 1);
    check("l4_food", food, exp_v);
    check("l4_food_ok", ok(food, food_exp, 4), 1);
    food_exp = exp_v;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy || done) cnt_a++;
    end
    check("l4_no_requeue", cnt_a, 0);

    // snake_len above max clamps to 16 segments
    for (int i = 0; i < 16; i++) body_mem[i] = 10'(200 + i);
    wait_valid(16);
    req = 1'b1; snake_len = 5'd20;
    tick();
    req = 1'b0;
    exp_v = m;
    for (int i = 0; i < 17; i++) tick();
    check("clamp_idx15", body_idx, 15);
    check("clamp_done_early", done, 0);
    tick();
    check("clamp_done", done, 1);
    check("clamp_food", food, exp_v);
    food_exp = exp_v;
    tick();

    // 5: reset during SCAN idx 1
    body_mem[0] = 10'd5; body_mem[1] = 10'd6; body_mem[2] = 10'd7; body_mem[3] = 10'd8;
    wait_valid(4);
    req = 1'b1; snake_len = 5'd4;
    tick();
    req = 1'b0;
    tick(); tick();
    check("mid_idx1", body_idx, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_food", food, 100);
    check("mid_rst_idx", body_idx, 0);
    rst_n = 1'b1;
    food_exp = 10'd100;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) cnt_a++;
    end
    check("mid_no_done", cnt_a, 0);

    // 4: collision on idx 2 sends FSM back to DRAW
    body_mem[2] = 10'd7;
    wait_valid(4);
    body_mem[2] = step(m);
    req = 1'b1; snake_len = 5'd4;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    check("hit_idx2", body_idx, 2);
    tick();
    check("hit_redraw_busy", busy, 1);
    check("hit_redraw_idx", body_idx, 2);
    tick(); tick();
    check("hit_no_early_done", done, 0);
    cnt_a = 0;
    while (!done && cnt_a < 500) begin
      tick();
      cnt_a++;
    end
    check("hit_done", done, 1);
    check("hit_food_ok", ok(food, food_exp, 4), 1);
    tick();

`ifdef FOOD_RETRY_LIMIT_EN
    // 6: every scan collides -> give up after 255 rejects
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    hit_all = 1'b1;
    req = 1'b1; snake_len = 5'd16;
    tick();
    req = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 20) req = 1'b1;
      if (i == 21) req = 1'b0;
      tick();
      if (done) cnt_a++;
      if (fail) cnt_b++;
    end
    check("lim_fail_once", cnt_b, 1);
    check("lim_no_done", cnt_a, 0);
    check("lim_food", food, 100);
    check("lim_idle", busy, 0);
    hit_all = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
